// File: rtl/avalon_uart_mailbox_slave_pkg.sv
// Shared constants and types for the UART-bridge mailbox slave.
package avalon_uart_pkg;

    localparam logic [4:0] ADDR_INSTR = 5'h00;
    localparam logic [4:0] ADDR_DATA  = 5'h04;
    localparam logic [4:0] ADDR_ADDR  = 5'h08;
    localparam logic [4:0] ADDR_TX    = 5'h0C;
    localparam logic [4:0] ADDR_CTRL  = 5'h10;

    typedef enum logic [1:0] {
        TAG_INSTR = 2'd0,
        TAG_DATA  = 2'd1,
        TAG_ADDR  = 2'd2,
        TAG_CTRL  = 2'd3
    } rx_tag_t;

    typedef enum logic [1:0] {
        IDLE,
        WR_STALL,
        RD_STALL,
        RD_RESP
    } mbox_state_t;

    // Status fields are 8 bits wide; a 256-deep FIFO saturates rather than reading back as 0.
    function automatic logic [7:0] sat_count8(input logic [31:0] c);
        return (c > 32'd255) ? 8'hFF : c[7:0];
    endfunction

endpackage

// File: rtl/avalon_uart_mailbox_slave_if.sv
// Avalon-MM bus between the UART bridge master and the mailbox slave.
interface avalon_uart_mailbox_slave_if;

    logic [31:0] ADDRESS;
    logic        BEGINTRANSFER;
    logic        READ;
    logic        WRITE;
    logic [31:0] WRITEDATA;
    logic        LOCK;
    logic [31:0] READDATA;
    logic        WAITREQUEST;

    modport master (
        output ADDRESS, BEGINTRANSFER, READ, WRITE, WRITEDATA, LOCK,
        input  READDATA, WAITREQUEST
    );

    modport slave (
        input  ADDRESS, BEGINTRANSFER, READ, WRITE, WRITEDATA, LOCK,
        output READDATA, WAITREQUEST
    );

endinterface

// File: rtl/avalon_uart_mailbox_slave_fifo.sv
// Synchronous FIFO with occupancy count; push ignored when full, pop ignored when empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/avalon_uart_mailbox_slave.sv
// Avalon-MM slave terminating the UART bridge: tagged writes feed an RX FIFO,
// reads of the TX address drain a TX FIFO, with bounded stall on empty.
module avalon_uart_mailbox_slave
    import avalon_uart_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned TIMEOUT      = 1024,
    parameter logic [31:0] TIMEOUT_WORD = 32'hDEADBEEF
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    avalon_uart_mailbox_slave_if.slave    bus,
    output logic [31:0]                   rx_data,
    output logic [1:0]                    rx_tag,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    input  logic [31:0]                   tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          timeout_err
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    mbox_state_t   state;
    mbox_state_t   state_next;
    logic [TW-1:0] timer;
    logic          timer_clr;
    logic          timer_inc;
    logic          timeout_hit;

    logic          stall;
    logic          rd_load;
    logic [31:0]   rd_next;
    logic          err_set;
    logic          err_clr;

    logic [4:0]    addr;
    logic          wr_mapped;
    rx_tag_t       wr_tag;
    logic [31:0]   status;

    logic          rx_push;
    logic          rx_full;
    logic          rx_empty;
    logic [CW-1:0] rx_count;
    logic [33:0]   rx_head;

    logic          tx_push;
    logic          tx_pop;
    logic          tx_full;
    logic          tx_empty;
    logic [CW-1:0] tx_count;
    logic [31:0]   tx_head;

    logic          unused_bits;

    assign unused_bits = ^{bus.ADDRESS[31:5], bus.BEGINTRANSFER, bus.LOCK};

    assign addr     = bus.ADDRESS[4:0];
    assign status   = {timeout_err, 15'd0, sat_count8(32'(tx_count)), sat_count8(32'(rx_count))};
    assign tx_push  = tx_valid && !tx_full;
    assign tx_ready = !tx_full;
    assign rx_valid = !rx_empty;
    assign rx_tag   = rx_head[33:32];
    assign rx_data  = rx_head[31:0];

    assign bus.WAITREQUEST = stall;

    // A push landing in the final stall cycle defers the timeout so the word is popped next cycle.
    assign timeout_hit = (timer == TW'(TIMEOUT - 1)) && !tx_push;

    always_comb begin
        wr_mapped = 1'b1;
        wr_tag    = TAG_INSTR;
        case (addr)
            ADDR_INSTR: wr_tag = TAG_INSTR;
            ADDR_DATA:  wr_tag = TAG_DATA;
            ADDR_ADDR:  wr_tag = TAG_ADDR;
            ADDR_CTRL:  wr_tag = TAG_CTRL;
            default:    wr_mapped = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        rx_push    = 1'b0;
        tx_pop     = 1'b0;
        rd_load    = 1'b0;
        rd_next    = '0;
        timer_clr  = 1'b0;
        timer_inc  = 1'b0;
        err_set    = 1'b0;
        err_clr    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.WRITE) begin
                    if (wr_mapped) begin
                        if (rx_full) begin
                            stall      = 1'b1;
                            state_next = WR_STALL;
                        end else begin
                            rx_push = 1'b1;
                        end
                    end
                end else if (bus.READ) begin
                    stall      = 1'b1;
                    state_next = RD_RESP;
                    rd_load    = 1'b1;
                    if (addr == ADDR_TX) begin
                        if (!tx_empty) begin
                            tx_pop  = 1'b1;
                            rd_next = tx_head;
                        end else begin
                            rd_load    = 1'b0;
                            timer_clr  = 1'b1;
                            state_next = RD_STALL;
                        end
                    end else if (addr == ADDR_CTRL) begin
                        rd_next = status;
                        err_clr = 1'b1;
                    end
                end
            end
            WR_STALL: begin
                if (!bus.WRITE || !wr_mapped) begin
                    state_next = IDLE;
                end else if (rx_full) begin
                    stall = 1'b1;
                end else begin
                    rx_push    = 1'b1;
                    state_next = IDLE;
                end
            end
            RD_STALL: begin
                if (!bus.READ) begin
                    state_next = IDLE;
                end else begin
                    stall     = 1'b1;
                    timer_inc = 1'b1;
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        rd_load    = 1'b1;
                        rd_next    = tx_head;
                        state_next = RD_RESP;
                    end else if (timeout_hit) begin
                        rd_load    = 1'b1;
                        rd_next    = TIMEOUT_WORD;
                        err_set    = 1'b1;
                        state_next = RD_RESP;
                    end
                end
            end
            RD_RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state        <= IDLE;
            timer        <= '0;
            bus.READDATA <= '0;
            timeout_err  <= 1'b0;
        end else begin
            state <= state_next;
            if (timer_clr)      timer <= '0;
            else if (timer_inc) timer <= timer + TW'(1);
            if (rd_load) bus.READDATA <= rd_next;
            if (err_set)      timeout_err <= 1'b1;
            else if (err_clr) timeout_err <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (34),
        .DEPTH (DEPTH)
    ) u_rx_fifo (
        .clk       (CLK),
        .rst_n     (RST_N),
        .push      (rx_push),
        .push_data ({wr_tag, bus.WRITEDATA}),
        .pop       (rx_ready),
        .pop_data  (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_tx_fifo (
        .clk       (CLK),
        .rst_n     (RST_N),
        .push      (tx_push),
        .push_data (tx_data),
        .pop       (tx_pop),
        .pop_data  (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

endmodule
